// File: rtl/counter_load_sequencer_if.sv
// rtl/counter_load_sequencer_if.sv - preset push channel between producer and reload sequencer
interface counter_load_sequencer_if #(
  parameter int unsigned W = 4
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/counter_load_sequencer.sv
// rtl/counter_load_sequencer.sv - preset FIFO and reload sequencer feeding a loadable up-counter
module counter_load_sequencer #(
  parameter int unsigned  W     = 4,
  parameter int unsigned  DEPTH = 4,
  parameter logic [W-1:0] TERM  = {W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     clr,
  counter_load_sequencer_if.slave  in_if,
  input  logic [W-1:0]             cnt_value_i,
  input  logic                     miss_ack_i,
  output logic                     load_o,
  output logic [W-1:0]             load_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     miss_o
);

  localparam int unsigned   PW         = $clog2(DEPTH);
  localparam int unsigned   LW         = $clog2(DEPTH) + 1;
  // Reload fires one count early so the counter shows TERM for one cycle.
  localparam logic [W-1:0]  PRE        = TERM - {{(W-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           load_q, load_d;
  logic [W-1:0]   load_data_q, load_data_d;
  logic           miss_q, miss_d;
  logic           full;
  logic           push;
  logic           pop;
  logic           hit;

  assign full           = (level_q == FULL_LEVEL);
  assign in_if.in_ready = ~full;
  assign push           = in_if.in_valid & ~full;
  assign hit            = (cnt_value_i == PRE);

  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    load_data_d = load_data_q;
    pop         = 1'b0;
    miss_d      = miss_q & ~miss_ack_i;
    case (state_q)
      IDLE: begin
        // A push landing on the trigger edge is too late to be loaded.
        if (hit) begin
          miss_d = 1'b1;
        end
        if (push) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (hit) begin
          load_d      = 1'b1;
          load_data_d = mem_q[rd_ptr_q];
          pop         = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        state_d = ((level_q != '0) || push) ? ARMED : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      load_q      <= 1'b0;
      load_data_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      load_q      <= load_d;
      load_data_q <= load_data_d;
      miss_q      <= miss_d;
    end
  end

  // Storage needs no reset: the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

  assign load_o      = load_q;
  assign load_data_o = load_data_q;
  assign level_o     = level_q;
  assign miss_o      = miss_q;

endmodule

// File: tb/tb_counter_load_sequencer.sv
// tb/tb_counter_load_sequencer.sv - directed self-checking bench for counter_load_sequencer
module tb_counter_load_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] cnt;
  logic       miss_ack;
  logic       load;
  logic [3:0] load_data;
  logic [2:0] level;
  logic       miss;
  int         errors = 0;
  int         checks = 0;

  counter_load_sequencer_if #(.W(4)) in_if ();

  counter_load_sequencer #(.W(4), .DEPTH(4), .TERM(4'hF)) dut (
    .clk         (clk),
    .clr         (clr),
    .in_if       (in_if),
    .cnt_value_i (cnt),
    .miss_ack_i  (miss_ack),
    .load_o      (load),
    .load_data_o (load_data),
    .level_o     (level),
    .miss_o      (miss)
  );

  always #5 clk = ~clk;

  // Loadable up-counter driven by the sequencer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt <= 4'h0;
    else if (load) cnt <= load_data;
    else cnt <= cnt + 4'h1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input string tag, input logic [3:0] v);
    int n = 0;
    while (cnt !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(cnt), 8'(v));
  endtask

  initial begin
    clr = 1'b0;
    miss_ack = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_load", 8'(load), 8'h00);
    check("rst_level", 8'(level), 8'h00);
    check("rst_miss", 8'(miss), 8'h00);
    clr = 1'b1;
    #1 check("rst_ready", 8'(in_if.in_ready), 8'h01);

    // single preset 3
    wait_cnt("t2_wait2", 4'h2);
    in_if.in_valid = 1'b1;
    in_if.in_data = 4'h3;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check("t2_level1", 8'(level), 8'h01);
    check("t2_cnt3", 8'(cnt), 8'h03);
    wait_cnt("t2_waitE", 4'hE);
    check("t2_noload_pre", 8'(load), 8'h00);
    @(negedge clk);
    check("t2_load", 8'(load), 8'h01);
    check("t2_load_data", 8'(load_data), 8'h03);
    check("t2_cntF", 8'(cnt), 8'h0F);
    check("t2_level0", 8'(level), 8'h00);
    @(negedge clk);
    check("t2_load_drop", 8'(load), 8'h00);
    check("t2_cnt_loaded", 8'(cnt), 8'h03);
    check("t2_data_hold", 8'(load_data), 8'h03);
    @(negedge clk);
    check("t2_cnt4", 8'(cnt), 8'h04);
    check("t2_miss0", 8'(miss), 8'h00);

    // empty FIFO reaches terminal
    wait_cnt("t4_waitE", 4'hE);
    check("t4_miss_pre", 8'(miss), 8'h00);
    @(negedge clk);
    check("t4_miss_set", 8'(miss), 8'h01);
    check("t4_noload", 8'(load), 8'h00);
    @(negedge clk);
    check("t4_wrap", 8'(cnt), 8'h00);
    miss_ack = 1'b1;
    @(negedge clk);
    miss_ack = 1'b0;
    check("t4_ack_clear", 8'(miss), 8'h00);
    wait_cnt("t4_waitE2", 4'hE);
    @(negedge clk);
    check("t4_miss_set2", 8'(miss), 8'h01);
    wait_cnt("t4_waitE3", 4'hE);
    miss_ack = 1'b1;
    @(negedge clk);
    check("t4_set_wins", 8'(miss), 8'h01);
    @(negedge clk);
    miss_ack = 1'b0;
    check("t4_ack_clear2", 8'(miss), 8'h00);
    check("t4_cnt0", 8'(cnt), 8'h00);

    // fill with E,C,D,5 then 9 held back by full
    in_if.in_valid = 1'b1;
    in_if.in_data = 4'hE;
    @(negedge clk);
    check("t3_level1", 8'(level), 8'h01);
    in_if.in_data = 4'hC;
    @(negedge clk);
    check("t3_level2", 8'(level), 8'h02);
    in_if.in_data = 4'hD;
    @(negedge clk);
    check("t3_level3", 8'(level), 8'h03);
    in_if.in_data = 4'h5;
    @(negedge clk);
    check("t3_level4", 8'(level), 8'h04);
    check("t3_not_ready", 8'(in_if.in_ready), 8'h00);
    in_if.in_data = 4'h9;
    @(negedge clk);
    check("t3_full_hold", 8'(level), 8'h04);
    wait_cnt("t3_waitE", 4'hE);
    check("t3_still_full", 8'(in_if.in_ready), 8'h00);
    @(negedge clk);
    check("t3_load", 8'(load), 8'h01);
    check("t3_load_data", 8'(load_data), 8'h0E);
    check("t3_level_pop", 8'(level), 8'h03);
    check("t3_ready_pop", 8'(in_if.in_ready), 8'h01);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check("t3_fifth_in", 8'(level), 8'h04);
    check("t3_load_drop", 8'(load), 8'h00);

    // preset E lands on pre: reload C after one cycle at F
    check("t5_cntE", 8'(cnt), 8'h0E);
    @(negedge clk);
    check("t5_load_c", 8'(load), 8'h01);
    check("t5_data_c", 8'(load_data), 8'h0C);
    check("t5_cntF", 8'(cnt), 8'h0F);
    check("t5_level3", 8'(level), 8'h03);
    @(negedge clk);
    check("t5_no_b2b", 8'(load), 8'h00);
    check("t5_cntC", 8'(cnt), 8'h0C);

    // push coincident with pop at level 2
    wait_cnt("t6_waitE", 4'hE);
    @(negedge clk);
    check("t6_data_d", 8'(load_data), 8'h0D);
    check("t6_level2", 8'(level), 8'h02);
    wait_cnt("t6_waitE2", 4'hE);
    in_if.in_valid = 1'b1;
    in_if.in_data = 4'hA;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check("t6_load", 8'(load), 8'h01);
    check("t6_data_5", 8'(load_data), 8'h05);
    check("t6_level_same", 8'(level), 8'h02);
    @(negedge clk);
    check("t6_cnt5", 8'(cnt), 8'h05);
    wait_cnt("t6_waitE3", 4'hE);
    @(negedge clk);
    check("t6_data_9", 8'(load_data), 8'h09);
    check("t6_level1", 8'(level), 8'h01);
    check("t6_load9", 8'(load), 8'h01);

    // asynchronous reset during the load pulse
    clr = 1'b0;
    #1;
    check("t1_load_async", 8'(load), 8'h00);
    check("t1_level_async", 8'(level), 8'h00);
    check("t1_miss_async", 8'(miss), 8'h00);
    check("t1_data_async", 8'(load_data), 8'h00);
    @(negedge clk);
    clr = 1'b1;
    #1 check("t1_ready", 8'(in_if.in_ready), 8'h01);
    wait_cnt("t1_waitE", 4'hE);
    @(negedge clk);
    check("t1_discarded_noload", 8'(load), 8'h00);
    check("t1_discarded_miss", 8'(miss), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
